// File: rtl/imem_loader.sv
// Boot loader: parses a [N:4B LE][4N payload bytes][XOR checksum] byte stream into 32-bit instruction memory writes.
// Latency: each write strobes one cycle after the word's 4th byte is accepted; in_ready is state-based, memory never backpressures.
module imem_loader #(
  parameter int REG_BITS    = 32,
  parameter int DEPTH_WORDS = 32768
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                we,
  output logic [REG_BITS-1:0] waddr,
  output logic [REG_BITS-1:0] wdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cpu_hold
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE, ERR} state_t;

  localparam logic [REG_BITS-1:0] DEPTH_L = REG_BITS'(DEPTH_WORDS);

  state_t              state, state_nxt;
  logic                accept;
  logic [1:0]          hcnt, bcnt;
  logic [REG_BITS-1:0] nwords, wcnt, word_buf;
  logic [REG_BITS-1:0] hdr_full, word_full;
  logic [7:0]          csum;

  assign in_ready  = (state == HDR) || (state == DATA) || (state == CHK);
  assign accept    = in_valid && in_ready;
  // Bytes shift in from the top, so after four accepts the first byte sits in [7:0].
  assign hdr_full  = {in_data, nwords[REG_BITS-1:8]};
  assign word_full = {in_data, word_buf[REG_BITS-1:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_hold  = 1'b1;
    case (state)
      HDR, DATA, CHK: busy = 1'b1;
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
    if (start) begin
      state_nxt = HDR;
    end else if (accept) begin
      case (state)
        HDR: if (hcnt == 2'd3) begin
          if (hdr_full > DEPTH_L)  state_nxt = ERR;
          else if (hdr_full == '0) state_nxt = CHK;
          else                     state_nxt = DATA;
        end
        DATA: if (bcnt == 2'd3 && wcnt == nwords - REG_BITS'(1)) state_nxt = CHK;
        CHK:     state_nxt = (in_data == csum) ? DONE : ERR;
        default: ;
      endcase
    end
  end

  // start takes priority over a same-cycle byte, discarding it and any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      bcnt     <= '0;
      wcnt     <= '0;
      nwords   <= '0;
      word_buf <= '0;
      csum     <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
    end else begin
      we <= 1'b0;
      if (start) begin
        hcnt     <= '0;
        bcnt     <= '0;
        wcnt     <= '0;
        nwords   <= '0;
        word_buf <= '0;
        csum     <= '0;
      end else if (accept) begin
        case (state)
          HDR: begin
            nwords <= hdr_full;
            hcnt   <= hcnt + 2'd1;
          end
          DATA: begin
            word_buf <= word_full;
            csum     <= csum ^ in_data;
            bcnt     <= bcnt + 2'd1;
            if (bcnt == 2'd3) begin
              we    <= 1'b1;
              waddr <= wcnt;
              wdata <= word_full;
              wcnt  <= wcnt + REG_BITS'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: expected writes are queued at stimulus time and popped by a write monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, we, busy, done, error, cpu_hold;
  logic [31:0] waddr, wdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  tx[$];
  logic [31:0] mon_a, mon_d;

  localparam logic [5:0] ST_RESET = 6'b000001;
  localparam logic [5:0] ST_DONE  = 6'b000100;
  localparam logic [5:0] ST_ERR   = 6'b000011;
  localparam logic [5:0] ST_BUSY  = 6'b101001;

  imem_loader #(.REG_BITS(32), .DEPTH_WORDS(32768)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Every write must match the oldest expected write; an unrequested write is a failure.
  always @(negedge clk) begin
    if (rst_n && we) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %h, none expected", waddr, wdata);
      end else begin
        mon_a = exp_addr_q.pop_front();
        mon_d = exp_data_q.pop_front();
        if (waddr !== mon_a || wdata !== mon_d) begin
          errors++;
          $display("FAIL write: got addr %0h data %h, expected addr %0h data %h",
                   waddr, wdata, mon_a, mon_d);
        end
      end
    end
  end

  function automatic logic [5:0] status();
    return {in_ready, we, busy, done, error, cpu_hold};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic put32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx.push_back(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data  = 8'hA5;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: byte %h not accepted within 50 cycles", b);
    end
  endtask

  task automatic send_tx(input bit gaps);
    while (tx.size() > 0) send_byte(tx.pop_front(), gaps);
  endtask

  task automatic settle(input string name, input logic [5:0] exp_st);
    repeat (3) @(posedge clk);
    #1;
    check({name, "_status"}, 64'(status()), 64'(exp_st));
    check({name, "_writes_left"}, 64'(exp_addr_q.size()), 64'd0);
  endtask

  // N=2 image; payload XOR is 13^93^10 = 0x90.
  task automatic image_two(input logic [7:0] chk);
    put32(32'd2);
    put32(32'h00000013);
    put32(32'h00100093);
    tx.push_back(chk);
    expect_wr(32'd0, 32'h00000013);
    expect_wr(32'd1, 32'h00100093);
  endtask

  initial begin
    #3;
    check("reset_status", 64'(status()), 64'(ST_RESET));
    check("reset_waddr", 64'(waddr), 64'd0);
    check("reset_wdata", 64'(wdata), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_status", 64'(status()), 64'(ST_RESET));

    // Good N=2 image
    image_two(8'h90);
    pulse_start();
    send_tx(1'b0);
    settle("n2_good", ST_DONE);

    // Same image, bad checksum 0x00
    image_two(8'h00);
    pulse_start();
    send_tx(1'b0);
    settle("n2_bad0", ST_ERR);

    // Same image, checksum 0x93 is not the payload XOR
    image_two(8'h93);
    pulse_start();
    send_tx(1'b0);
    settle("n2_bad93", ST_ERR);

    // Oversized header: 0x8001 > 32768 words
    put32(32'h00008001);
    pulse_start();
    send_tx(1'b0);
    settle("too_big", ST_ERR);

    // Header exactly DEPTH_WORDS is accepted; abort it right after the header
    put32(32'h00008000);
    pulse_start();
    send_tx(1'b0);
    @(posedge clk); #1;
    check("depth_max_busy", 64'(status()), 64'(ST_BUSY));

    // Empty image
    put32(32'd0);
    tx.push_back(8'h00);
    pulse_start();
    send_tx(1'b0);
    settle("n0", ST_DONE);

    // N=3 with random valid gaps; XOR of 11..cc payload = 0xcc
    put32(32'd3);
    put32(32'h44332211);
    put32(32'h88776655);
    put32(32'hccbbaa99);
    tx.push_back(8'hcc);
    expect_wr(32'd0, 32'h44332211);
    expect_wr(32'd1, 32'h88776655);
    expect_wr(32'd2, 32'hccbbaa99);
    pulse_start();
    send_tx(1'b1);
    settle("n3_gaps", ST_DONE);

    // Abort after 6 payload bytes: one write only, then fresh load from word 0
    put32(32'd3);
    put32(32'h44332211);
    tx.push_back(8'h55);
    tx.push_back(8'h66);
    expect_wr(32'd0, 32'h44332211);
    pulse_start();
    send_tx(1'b0);
    pulse_start();
    check("abort_busy", 64'(status()), 64'(ST_BUSY));
    check("abort_writes_left", 64'(exp_addr_q.size()), 64'd0);
    image_two(8'h90);
    send_tx(1'b0);
    settle("after_abort", ST_DONE);

    // Start coinciding with a byte: the byte is dropped, header restarts cleanly
    pulse_start();
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h07;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    image_two(8'h90);
    send_tx(1'b0);
    settle("start_wins", ST_DONE);

    // Asynchronous reset in the middle of word 1
    put32(32'd2);
    put32(32'h00000013);
    tx.push_back(8'h93);
    tx.push_back(8'h00);
    expect_wr(32'd0, 32'h00000013);
    pulse_start();
    send_tx(1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_status", 64'(status()), 64'(ST_RESET));
    check("midreset_waddr", 64'(waddr), 64'd0);
    check("midreset_wdata", 64'(wdata), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("postreset_status", 64'(status()), 64'(ST_RESET));
    image_two(8'h90);
    pulse_start();
    send_tx(1'b0);
    settle("after_reset", ST_DONE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
